// File: rtl/alu_seq.sv
// alu_seq: multi-cycle accumulator ALU between the register file read ports
// and its write port. Operands are captured when an operation is accepted.
// The result is then written back with a single-cycle write_enabled pulse.
// Build option MUL_EN: when defined, op 110 is a W-cycle shift-add multiply.
// When undefined, op 110 is illegal: one EXEC cycle, then a WB with no write,
// and no multiply hardware is built.
module alu_seq #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [D-1:0] dest,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic         busy,
  output logic         done,
  output logic         write_enabled,
  output logic [D-1:0] reg_write_number,
  output logic [W-1:0] reg_write_data,
  output logic         carry,
  output logic         zero
);

  localparam int CW = (($clog2(W) + 1) > 3) ? ($clog2(W) + 1) : 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [D-1:0]   dest_q, dest_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   reg_q, reg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D-1:0]   wrNum_q, wrNum_d;
  logic [W-1:0]   wrData_q, wrData_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic [W-1:0]   result;
  logic           resCarry;
  logic           opLegal;
`ifdef MUL_EN
  logic [W-1:0]   hi_q, hi_d;
  logic [W:0]     mulSum;
`endif

`ifdef MUL_EN
  assign opLegal = 1'b1;
`else
  assign opLegal = (op_q != OP_MUL);
`endif

  // State, captured operands, working registers and held results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dest_q   <= '0;
      acc_q    <= '0;
      reg_q    <= '0;
      cnt_q    <= '0;
      wrNum_q  <= '0;
      wrData_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef MUL_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      acc_q    <= acc_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      wrNum_q  <= wrNum_d;
      wrData_q <= wrData_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef MUL_EN
      hi_q     <= hi_d;
`endif
    end
  end

  // Next state: accept in IDLE, iterate in EXEC, commit the result on the last iteration.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dest_d   = dest_q;
    acc_d    = acc_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    wrNum_d  = wrNum_q;
    wrData_d = wrData_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    result   = '0;
    resCarry = 1'b0;
`ifdef MUL_EN
    hi_d     = hi_q;
    mulSum   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          op_d    = op;
          dest_d  = dest;
          acc_d   = acc_in;
          reg_d   = reg_in;
          cnt_d   = '0;
          if ((op == OP_SHL || op == OP_SHR) && reg_in[2:0] != 3'd0) begin
            cnt_d = CW'(reg_in[2:0]) - CW'(1);
          end
`ifdef MUL_EN
          hi_d = '0;
          if (op == OP_MUL) begin
            cnt_d = CW'(W - 1);
          end
`endif
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD:  {resCarry, result} = {1'b0, acc_q} + {1'b0, reg_q};
          OP_SUB: begin
            result   = acc_q - reg_q;
            resCarry = (acc_q < reg_q);
          end
          OP_AND:  result = acc_q & reg_q;
          OP_XOR:  result = acc_q ^ reg_q;
          OP_SHL: begin
            result = acc_q;
            if (reg_q[2:0] != 3'd0) begin
              resCarry = acc_q[W-1];
              result   = {acc_q[W-2:0], 1'b0};
            end
            acc_d = result;
          end
          OP_SHR: begin
            result = acc_q;
            if (reg_q[2:0] != 3'd0) begin
              resCarry = acc_q[0];
              result   = {1'b0, acc_q[W-1:1]};
            end
            acc_d = result;
          end
`ifdef MUL_EN
          OP_MUL: begin
            mulSum   = {1'b0, hi_q} + (reg_q[0] ? {1'b0, acc_q} : {(W+1){1'b0}});
            hi_d     = mulSum[W:1];
            reg_d    = {mulSum[0], reg_q[W-1:1]};
            result   = reg_d;
            resCarry = |hi_d;
          end
`endif
          OP_PASS: result = reg_q;
          default: result = '0;
        endcase
        if (cnt_q == '0) begin
          state_d = WB;
          if (opLegal) begin
            wrNum_d  = dest_q;
            wrData_d = result;
            carry_d  = resCarry;
            zero_d   = (result == '0);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == WB);
  assign write_enabled    = (state_q == WB) && opLegal;
  assign reg_write_number = wrNum_q;
  assign reg_write_data   = wrData_q;
  assign carry            = carry_q;
  assign zero             = zero_q;

endmodule
